// File: rtl/voxel_gpu_swap_csr.sv
// Avalon-MM CSR slave for the voxel GPU: front/back buffer bases, vsync-synchronised
// swap with maskable completion interrupt, scratch registers and registered reads.
module voxel_gpu_swap_csr #(
    parameter int unsigned       DATA_W        = 32,
    parameter int unsigned       ADDR_W        = 8,
    parameter int unsigned       NUM_USER_REGS = 4,
    parameter logic [DATA_W-1:0] RESET_FRONT   = '0,
    parameter logic [DATA_W-1:0] RESET_BACK    = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    output logic [DATA_W-1:0] s1_readdata,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    input  logic              vsync,
    output logic [DATA_W-1:0] front_buffer,
    output logic [DATA_W-1:0] back_buffer,
    output logic              swap_pending,
    output logic              interrupt_sender_irq
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    localparam logic [ADDR_W-1:0] A_FRONT  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_BACK   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] front_q, front_d;
    logic [DATA_W-1:0] back_q, back_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_flag_q, irq_flag_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] user_q [NUM_USER_REGS];
    logic [DATA_W-1:0] user_d [NUM_USER_REGS];
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] rd_mux;
    logic              rd_capture;
    logic              swap_now;

    // A read alone (never alongside a write) is captured once, then presented the next cycle.
    assign rd_capture = s1_read && !s1_write && !rd_valid_q;
    assign swap_now   = (state_q == ST_PENDING) && vsync;

    always_comb begin
        rd_mux = '0;
        case (s1_address)
            A_FRONT:  rd_mux = front_q;
            A_BACK:   rd_mux = back_q;
            A_CTRL:   rd_mux = DATA_W'({irq_en_q, 1'b0});
            A_STATUS: rd_mux = DATA_W'({irq_flag_q, state_q == ST_PENDING});
            default:  rd_mux = '0;
        endcase
        for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
            if (s1_address == ADDR_W'(4 + i)) begin
                rd_mux = user_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        back_d     = back_q;
        irq_en_d   = irq_en_q;
        irq_flag_d = irq_flag_q;
        user_d     = user_q;
        irq_d      = irq_flag_q & irq_en_q;
        rd_valid_d = rd_capture;
        rdata_d    = rd_capture ? rd_mux : '0;

        if (s1_write) begin
            case (s1_address)
                A_BACK: begin
                    if (state_q == ST_IDLE) begin
                        back_d = s1_writedata;
                    end
                end
                A_CTRL: begin
                    irq_en_d = s1_writedata[1];
                    if (s1_writedata[0] && (state_q == ST_IDLE)) begin
                        state_d = ST_PENDING;
                    end
                end
                A_STATUS: begin
                    if (s1_writedata[1]) begin
                        irq_flag_d = 1'b0;
                    end
                end
                default: ;
            endcase
            for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
                if (s1_address == ADDR_W'(4 + i)) begin
                    user_d[i] = s1_writedata;
                end
            end
        end

        // Applied last so swap completion beats a same-cycle W1C of the flag.
        if (swap_now) begin
            front_d    = back_q;
            back_d     = front_q;
            irq_flag_d = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            front_q    <= RESET_FRONT;
            back_q     <= RESET_BACK;
            irq_en_q   <= 1'b0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
            user_q     <= '{default: '0};
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            back_q     <= back_d;
            irq_en_q   <= irq_en_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
            user_q     <= user_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s1_readdata          = rdata_q;
    assign s1_waitrequest       = rd_capture;
    assign front_buffer         = front_q;
    assign back_buffer          = back_q;
    assign swap_pending         = (state_q == ST_PENDING);
    assign interrupt_sender_irq = irq_q;

endmodule

// File: tb/tb_voxel_gpu_swap_csr.sv
// Directed bench for voxel_gpu_swap_csr: register-level model compared every cycle,
// plus literal expectations for the scenarios of interest.
module tb_voxel_gpu_swap_csr;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NU = 4;
    localparam logic [DW-1:0] RF = 32'h0;
    localparam logic [DW-1:0] RB = 32'h0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s1_address = '0;
    logic          s1_read = 1'b0;
    logic [DW-1:0] s1_readdata;
    logic          s1_write = 1'b0;
    logic [DW-1:0] s1_writedata = '0;
    logic          s1_waitrequest;
    logic          vsync = 1'b0;
    logic [DW-1:0] front_buffer;
    logic [DW-1:0] back_buffer;
    logic          swap_pending;
    logic          interrupt_sender_irq;

    voxel_gpu_swap_csr #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_USER_REGS(NU),
        .RESET_FRONT(RF), .RESET_BACK(RB)
    ) dut (
        .clock(clock), .reset(reset),
        .s1_address(s1_address), .s1_read(s1_read), .s1_readdata(s1_readdata),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
        .vsync(vsync), .front_buffer(front_buffer), .back_buffer(back_buffer),
        .swap_pending(swap_pending), .interrupt_sender_irq(interrupt_sender_irq)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Register-level model of the programmer-visible state.
    logic [DW-1:0] m_front, m_back;
    logic          m_pend, m_en, m_flag, m_irq;
    logic [DW-1:0] m_user [NU];
    bit            model_on = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_front <= RF;
            m_back  <= RB;
            m_pend  <= 1'b0;
            m_en    <= 1'b0;
            m_flag  <= 1'b0;
            m_irq   <= 1'b0;
            for (int i = 0; i < NU; i++) m_user[i] <= '0;
        end else begin
            m_irq <= m_flag & m_en;
            if (s1_write) begin
                if (s1_address == 1 && !m_pend) m_back <= s1_writedata;
                if (s1_address == 2) begin
                    m_en <= s1_writedata[1];
                    if (s1_writedata[0]) m_pend <= 1'b1;
                end
                if (s1_address == 3 && s1_writedata[1]) m_flag <= 1'b0;
                if (int'(s1_address) >= 4 && int'(s1_address) < 4 + NU)
                    m_user[int'(s1_address) - 4] <= s1_writedata;
            end
            if (m_pend && vsync) begin
                m_front <= m_back;
                m_back  <= m_front;
                m_flag  <= 1'b1;
                m_pend  <= 1'b0;
            end
        end
    end

    function automatic logic [DW-1:0] model_read(input int a);
        if (a == 0) return m_front;
        if (a == 1) return m_back;
        if (a == 2) return {30'b0, m_en, 1'b0};
        if (a == 3) return {30'b0, m_flag, m_pend};
        if (a >= 4 && a < 4 + NU) return m_user[a - 4];
        return '0;
    endfunction

    always @(negedge clock) begin
        if (model_on) begin
            chk("front_buffer", front_buffer, m_front);
            chk("back_buffer", back_buffer, m_back);
            chk("swap_pending", DW'(swap_pending), DW'(m_pend));
            chk("irq", DW'(interrupt_sender_irq), DW'(m_irq));
            if (!s1_read || s1_write) begin
                chk("idle_waitrequest", DW'(s1_waitrequest), 0);
                chk("idle_readdata", s1_readdata, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        s1_write = 1'b1; s1_address = a; s1_writedata = d;
        tick();
        s1_write = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
        logic [DW-1:0] e;
        e = model_read(int'(a));
        s1_read = 1'b1; s1_address = a;
        @(negedge clock);
        chk("rd_wait_first", DW'(s1_waitrequest), 1);
        tick();
        @(negedge clock);
        chk("rd_wait_second", DW'(s1_waitrequest), 0);
        chk("rd_data_model", s1_readdata, e);
        d = s1_readdata;
        tick();
        s1_read = 1'b0;
    endtask

    logic [DW-1:0] d;
    logic [DW-1:0] f_before;

    initial begin
        // 1: reset values and read handshake
        tick();
        model_on = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(AW'(a), d);
            chk("t1_reset_read", d, 32'h0);
        end

        // 2: basic swap with interrupt
        wr(8'h01, 32'h0010_0000);
        wr(8'h02, 32'h2);
        wr(8'h02, 32'h3);
        chk("t2_pending_set", DW'(swap_pending), 1);
        repeat (4) tick();
        pulse_vsync();
        chk("t2_pending_clr", DW'(swap_pending), 0);
        chk("t2_front", front_buffer, 32'h0010_0000);
        chk("t2_back", back_buffer, 32'h0);
        chk("t2_irq_not_yet", DW'(interrupt_sender_irq), 0);
        tick();
        chk("t2_irq_high", DW'(interrupt_sender_irq), 1);
        rd(8'h00, d);
        chk("t2_rd_front", d, 32'h0010_0000);
        wr(8'h03, 32'h2);
        tick();
        chk("t2_irq_cleared", DW'(interrupt_sender_irq), 0);

        // 3: request in the vsync cycle waits for the next vsync
        s1_write = 1'b1; s1_address = 8'h02; s1_writedata = 32'h3; vsync = 1'b1;
        tick();
        s1_write = 1'b0; vsync = 1'b0;
        chk("t3_pending", DW'(swap_pending), 1);
        chk("t3_front_kept", front_buffer, 32'h0010_0000);
        repeat (2) tick();
        pulse_vsync();
        chk("t3_front_swapped", front_buffer, 32'h0);
        chk("t3_back_swapped", back_buffer, 32'h0010_0000);

        // 4: BACK frozen while pending, repeated request not queued
        wr(8'h02, 32'h3);
        wr(8'h01, 32'hDEAD_BEEF);
        chk("t4_back_frozen", back_buffer, 32'h0010_0000);
        wr(8'h02, 32'h3);
        pulse_vsync();
        chk("t4_front", front_buffer, 32'h0010_0000);
        chk("t4_back", back_buffer, 32'h0);
        chk("t4_idle", DW'(swap_pending), 0);
        pulse_vsync();
        chk("t4_no_second_swap", front_buffer, 32'h0010_0000);
        wr(8'h01, 32'h0020_0000);
        chk("t4_back_idle_write", back_buffer, 32'h0020_0000);

        // 5: completion beats W1C; IRQ_EN=0 masks
        wr(8'h03, 32'h2);
        wr(8'h02, 32'h3);
        s1_write = 1'b1; s1_address = 8'h03; s1_writedata = 32'h2; vsync = 1'b1;
        tick();
        s1_write = 1'b0; vsync = 1'b0;
        rd(8'h03, d);
        chk("t5_status", d, 32'h2);
        wr(8'h02, 32'h0);
        repeat (2) tick();
        chk("t5_irq_masked", DW'(interrupt_sender_irq), 0);
        rd(8'h03, d);
        chk("t5_flag_persists", d, 32'h2);
        rd(8'h02, d);
        chk("t5_ctrl", d, 32'h0);

        // user registers, unmapped and read-only addresses, read+write together
        for (int i = 0; i < NU; i++) wr(AW'(4 + i), 32'hA5A5_0000 + i);
        wr(8'h08, 32'hFFFF_FFFF);
        wr(8'h00, 32'h1234_5678);
        s1_read = 1'b1; s1_write = 1'b1; s1_address = 8'h05; s1_writedata = 32'h5555_AAAA;
        tick();
        s1_read = 1'b0; s1_write = 1'b0;
        rd(8'h04, d); chk("user0", d, 32'hA5A5_0000);
        rd(8'h05, d); chk("user1_rw", d, 32'h5555_AAAA);
        rd(8'h07, d); chk("user3", d, 32'hA5A5_0003);
        rd(8'h08, d); chk("unmapped", d, 32'h0);
        rd(8'h00, d); chk("front_ro", d, 32'h0020_0000);

        // 6: reset while pending abandons the swap
        wr(8'h02, 32'h1);
        chk("t6_pending", DW'(swap_pending), 1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        pulse_vsync();
        chk("t6_front", front_buffer, RF);
        chk("t6_back", back_buffer, RB);
        chk("t6_not_pending", DW'(swap_pending), 0);
        rd(8'hFF, d); chk("t6_addr_ff", d, 32'h0);
        rd(8'h04, d); chk("t6_user_reset", d, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
